track_section_arbiter: RTL and testbench

TRACK_SECTION_ARBITER -- requirements
Module: track_section_arbiter

---
 rtl/track_section_arbiter_if.sv | 21 ++
 rtl/track_section_arbiter.sv | 134 +++++++++++++
 tb/tb_track_section_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/track_section_arbiter_if.sv
// Signal bundle between the shared-section arbiter and the trackside equipment.
// The slave modport faces the arbiter; the master modport faces sensors and operator.
interface track_section_arbiter_if;
    logic [2:0] REQ;
    logic       EXIT;
    logic       FAULT_ACK;
    logic [2:0] GO;
    logic [1:0] SW;
    logic       BUSY;
    logic       FAULT;

    modport master (
        output REQ, EXIT, FAULT_ACK,
        input  GO, SW, BUSY, FAULT
    );

    modport slave (
        input  REQ, EXIT, FAULT_ACK,
        output GO, SW, BUSY, FAULT
    );
endinterface

// File: rtl/track_section_arbiter.sv
// Round-robin arbiter granting one of three trains access to a single shared track section,
// with switch settling, post-exit hold-off and an occupancy timeout that latches a fault.
module track_section_arbiter #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int CLEAR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    Clock,
    input  logic                    RESET,
    track_section_arbiter_if.slave  bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ROUTE = 3'd1;
    localparam logic [2:0] GRANT = 3'd2;
    localparam logic [2:0] CLEAR = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    // One shared counter serves all three timed states; 16 bits covers the largest legal limit.
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST   = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  winner_q, winner_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  go_q, go_d;
    logic [1:0]  sw_q, sw_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [1:0]  pick;

    // Search begins just after the last completed grant; the lowest offset with a request wins.
    always_comb begin
        logic [1:0] start;
        int         idx;
        start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        pick  = start;
        for (int i = 2; i >= 0; i--) begin
            idx = (int'(start) + i) % 3;
            if (bus.REQ[idx]) pick = 2'(idx);
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        sw_d     = sw_q;
        case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    winner_d = pick;
                    sw_d     = pick;
                    cnt_d    = 16'd0;
                    state_d  = ROUTE;
                end
            end
            ROUTE: begin
                if (!bus.REQ[winner_q]) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = GRANT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GRANT: begin
                // Exit is checked first so a train leaving on the final cycle is not faulted.
                if (bus.EXIT) begin
                    last_d  = winner_q;
                    cnt_d   = 16'd0;
                    state_d = CLEAR;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FAULT: begin
                if (bus.FAULT_ACK) state_d = IDLE;
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = IDLE;
            end
        endcase

        go_d    = (state_d == GRANT) ? (3'b001 << winner_d) : 3'b000;
        busy_d  = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge Clock) begin
        if (RESET) begin
            state_q  <= IDLE;
            winner_q <= 2'd0;
            last_q   <= 2'd2;
            cnt_q    <= 16'd0;
            go_q     <= 3'b000;
            sw_q     <= 2'd0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            go_q     <= go_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.GO    = go_q;
    assign bus.SW    = sw_q;
    assign bus.BUSY  = busy_q;
    assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_track_section_arbiter.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle number,
// and a monitor compares every observed change of {GO,SW,BUSY,FAULT} against the queue head.
module tb_track_section_arbiter;

    typedef struct {
        int         cyc;
        logic [2:0] go;
        logic [1:0] sw;
        logic       busy;
        logic       fault;
    } ev_t;

    logic Clock = 1'b0;
    logic RESET;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   stim_done = 1'b0;
    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];

    track_section_arbiter_if bus();

    track_section_arbiter dut (
        .Clock (Clock),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic expect_ev(input int c, input logic [2:0] go, input logic [1:0] sw,
                             input logic busy, input logic fault);
        ev_t e;
        e.cyc = c; e.go = go; e.sw = sw; e.busy = busy; e.fault = fault;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [2:0] req, input logic exit_i, input logic ack);
        bus.REQ       = req;
        bus.EXIT      = exit_i;
        bus.FAULT_ACK = ack;
    endtask

    task automatic check_output(input logic [6:0] cur);
        ev_t        e;
        logic [6:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event: cycle %0d GO=%b SW=%b BUSY=%b FAULT=%b, required no change",
                     cyc, cur[6:4], cur[3:2], cur[1], cur[0]);
        end else begin
            e    = exp_q.pop_front();
            want = {e.go, e.sw, e.busy, e.fault};
            if (e.cyc != cyc || want !== cur) begin
                failures++;
                $display("[TB] FAIL event: got cycle %0d GO=%b SW=%b BUSY=%b FAULT=%b, required cycle %0d GO=%b SW=%b BUSY=%b FAULT=%b",
                         cyc, cur[6:4], cur[3:2], cur[1], cur[0],
                         e.cyc, e.go, e.sw, e.busy, e.fault);
            end
        end
    endtask

    // Monitor: owns all counters, reports each output change and ends the run.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        bit         first;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge Clock);
            if (stim_done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("[TB] FAIL missing_events: got %0d outstanding, required 0 (next due cycle %0d)",
                             exp_q.size(), exp_q[0].cyc);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (mon_en) begin
                cur = {bus.GO, bus.SW, bus.BUSY, bus.FAULT};
                checks++;
                if ($countones(bus.GO) > 1) begin
                    failures++;
                    $display("[TB] FAIL go_onehot: cycle %0d GO=%b, required at most one bit", cyc, bus.GO);
                end
                if (first || cur !== prev) begin
                    first = 1'b0;
                    prev  = cur;
                    check_output(cur);
                end
            end
        end
    end

    initial begin
        int t;
        int s;
        int g;
        int w;

        RESET = 1'b1;
        apply_stimulus(3'b000, 1'b0, 1'b0);
        tick(2);
        expect_ev(2, 3'b000, 2'd0, 1'b0, 1'b0);
        mon_en = 1'b1;
        RESET  = 1'b0;

        // Two trains alternate: train 0 first after reset, then train 1.
        t = cyc;
        apply_stimulus(3'b011, 1'b0, 1'b0);
        expect_ev(t + 1, 3'b000, 2'd0, 1'b1, 1'b0);
        expect_ev(t + 9, 3'b001, 2'd0, 1'b1, 1'b0);
        wait_until(t + 12);
        bus.EXIT = 1'b1;
        expect_ev(t + 13, 3'b000, 2'd0, 1'b1, 1'b0);
        tick(1);
        bus.EXIT = 1'b0;
        expect_ev(t + 17, 3'b000, 2'd0, 1'b0, 1'b0);
        expect_ev(t + 18, 3'b000, 2'd1, 1'b1, 1'b0);
        expect_ev(t + 26, 3'b010, 2'd1, 1'b1, 1'b0);
        wait_until(t + 27);
        apply_stimulus(3'b000, 1'b1, 1'b0);
        expect_ev(t + 28, 3'b000, 2'd1, 1'b1, 1'b0);
        expect_ev(t + 32, 3'b000, 2'd1, 1'b0, 1'b0);
        tick(1);
        bus.EXIT = 1'b0;
        wait_until(t + 34);

        RESET = 1'b1;
        expect_ev(cyc + 1, 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        RESET = 1'b0;

        // All three requesting: grants rotate 0,1,2,0.
        t = cyc;
        bus.REQ = 3'b111;
        for (int k = 0; k < 4; k++) begin
            s = t + 1 + 15 * k;
            w = k % 3;
            expect_ev(s, 3'b000, 2'(w), 1'b1, 1'b0);
            expect_ev(s + 8, 3'b001 << w, 2'(w), 1'b1, 1'b0);
            wait_until(s + 9);
            bus.EXIT = 1'b1;
            expect_ev(s + 10, 3'b000, 2'(w), 1'b1, 1'b0);
            tick(1);
            bus.EXIT = 1'b0;
            if (k == 3) bus.REQ = 3'b000;
            expect_ev(s + 14, 3'b000, 2'(w), 1'b0, 1'b0);
        end
        wait_until(t + 62);

        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;

        // Abandoned route leaves priority untouched: train 0 still wins afterwards.
        t = cyc;
        bus.REQ = 3'b100;
        expect_ev(t + 1, 3'b000, 2'd2, 1'b1, 1'b0);
        wait_until(t + 3);
        bus.REQ = 3'b000;
        expect_ev(t + 4, 3'b000, 2'd2, 1'b0, 1'b0);
        wait_until(t + 5);
        bus.REQ = 3'b101;
        expect_ev(t + 6, 3'b000, 2'd0, 1'b1, 1'b0);
        expect_ev(t + 14, 3'b001, 2'd0, 1'b1, 1'b0);
        wait_until(t + 15);
        apply_stimulus(3'b000, 1'b1, 1'b0);
        expect_ev(t + 16, 3'b000, 2'd0, 1'b1, 1'b0);
        expect_ev(t + 20, 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        bus.EXIT = 1'b0;
        wait_until(t + 22);

        // Train 1 never exits: timeout fault, stray ACK and EXIT ignored where they do not apply.
        t = cyc;
        bus.REQ = 3'b010;
        expect_ev(t + 1, 3'b000, 2'd1, 1'b1, 1'b0);
        expect_ev(t + 9, 3'b010, 2'd1, 1'b1, 1'b0);
        wait_until(t + 10);
        bus.REQ = 3'b000;
        wait_until(t + 20);
        bus.FAULT_ACK = 1'b1;
        tick(1);
        bus.FAULT_ACK = 1'b0;
        expect_ev(t + 1033, 3'b000, 2'd1, 1'b1, 1'b1);
        wait_until(t + 1034);
        bus.EXIT = 1'b1;
        tick(1);
        bus.EXIT = 1'b0;
        wait_until(t + 1036);
        bus.FAULT_ACK = 1'b1;
        expect_ev(t + 1037, 3'b000, 2'd1, 1'b0, 1'b0);
        tick(1);
        bus.FAULT_ACK = 1'b0;
        wait_until(t + 1039);

        // Fault kept last at train 0, so train 1 wins; reset mid-grant restores train 0 priority.
        t = cyc;
        bus.REQ = 3'b111;
        expect_ev(t + 1, 3'b000, 2'd1, 1'b1, 1'b0);
        expect_ev(t + 9, 3'b010, 2'd1, 1'b1, 1'b0);
        wait_until(t + 12);
        RESET = 1'b1;
        expect_ev(t + 13, 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        RESET = 1'b0;
        expect_ev(t + 14, 3'b000, 2'd0, 1'b1, 1'b0);
        expect_ev(t + 22, 3'b001, 2'd0, 1'b1, 1'b0);

        // Exit arriving on the final timeout cycle must clear, not fault.
        g = t + 22;
        wait_until(g + 1023);
        apply_stimulus(3'b000, 1'b1, 1'b0);
        expect_ev(g + 1024, 3'b000, 2'd0, 1'b1, 1'b0);
        expect_ev(g + 1028, 3'b000, 2'd0, 1'b0, 1'b0);
        tick(1);
        bus.EXIT = 1'b0;
        wait_until(g + 1032);
        stim_done = 1'b1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of stimulus by cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
